// File: rtl/reglk_enforced_regfile.sv
// Lock-enforcing register bank: a req/gnt/rvalid bus in front of NUM_REGS 32-bit registers.
// Writes are denied until lock words are declared valid, and denied writes are logged as violations.
module reglk_enforced_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter int          REGLK_WORDS = 6,
  parameter int          ADDR_W      = 8,
  parameter int          CNT_W       = 8,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [32*REGLK_WORDS-1:0] reglk_i,
  input  logic                      reglk_valid_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                be_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      viol_o,
  output logic [ADDR_W-1:0]         viol_addr_o,
  output logic [CNT_W-1:0]          viol_cnt_o,
  input  logic                      viol_clr_i,
  output logic [32*NUM_REGS-1:0]    regs_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                armed_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         regs_q [NUM_REGS];
  logic                viol_q, viol_d;
  logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;

  logic                inRange;
  logic [IDX_W-1:0]    addrIdx;
  logic [NUM_REGS-1:0] lockVec;
  logic                locked;
  logic                isExec;
  logic                violation;
  logic                execErr;
  logic                doWrite;
  logic                unusedLockBits;

  // Lock bits of registers that do not exist are irrelevant here.
  assign unusedLockBits = ^reglk_i[32*REGLK_WORDS-1:NUM_REGS];

  assign gnt_o    = (state_q == IDLE) & ~rst_i;
  assign rvalid_o = (state_q == RESP);
  assign rdata_o  = rvalid_o ? rdata_q : 32'h0;
  assign err_o    = rvalid_o & err_q;

  assign viol_o      = viol_q;
  assign viol_addr_o = viol_addr_q;
  assign viol_cnt_o  = viol_cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_i) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Until armed, every register reads as locked regardless of the lock words.
  always_comb begin
    inRange   = (addr_q < ADDR_W'(NUM_REGS));
    addrIdx   = addr_q[IDX_W-1:0];
    lockVec   = ~{NUM_REGS{armed_q}} | reglk_i[NUM_REGS-1:0];
    locked    = inRange & lockVec[addrIdx];
    isExec    = (state_q == EXEC);
    violation = isExec & we_q & locked;
    execErr   = ~inRange | (we_q & locked);
    doWrite   = isExec & we_q & inRange & ~locked;
  end

  always_comb begin
    viol_d      = viol_q;
    viol_addr_d = viol_addr_q;
    viol_cnt_d  = viol_cnt_q;
    if (viol_clr_i) begin
      viol_d      = 1'b0;
      viol_addr_d = '0;
      viol_cnt_d  = '0;
    end
    if (violation) begin
      viol_d = 1'b1;
      if (viol_clr_i || !viol_q) viol_addr_d = addr_q;
      viol_cnt_d = (viol_cnt_d == CNT_MAX) ? CNT_MAX : viol_cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      viol_q      <= 1'b0;
      viol_addr_q <= '0;
      viol_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_q | reglk_valid_i;
      viol_q      <= viol_d;
      viol_addr_q <= viol_addr_d;
      viol_cnt_q  <= viol_cnt_d;
      if (state_q == IDLE && req_i) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        be_q    <= be_i;
      end
      if (isExec) begin
        err_q   <= execErr;
        rdata_q <= (!execErr && !we_q) ? regs_q[addrIdx] : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else if (doWrite) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) regs_q[addrIdx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_regs_out
    assign regs_o[32*g +: 32] = regs_q[g];
  end

endmodule
